// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
package mem_arb_pkg;

  localparam int unsigned WDOG_W = 16;
  localparam int unsigned DATA_W = 32;
  localparam logic [DATA_W-1:0] ERR_WORD_DEF = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {IDLE, DACC, IACC} arb_state_t;

  // Command held on the memory bus for the duration of one access
  typedef struct packed {
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/wdog_counter.sv
// Watchdog for an outstanding memory request; flags the last allowed unacked cycle.
module wdog_counter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic done_c
);

  logic [WDOG_W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + WDOG_W'(1);
    end
  end

  // Terminal cycle: this unacked cycle is the TIMEOUT_CYC-th one
  assign done_c = en && (count == WDOG_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Serialises IF-stage fetches and MEM-stage loads/stores onto one memory port.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned       TIMEOUT_CYC = 255,
  parameter logic [DATA_W-1:0] ERR_WORD    = ERR_WORD_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [DATA_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              err
);

  arb_state_t        state, state_n;
  mem_cmd_t          cmd, cmd_n;
  logic              req_n;
  logic              if_valid_n, dm_valid_n, err_n;
  logic [DATA_W-1:0] if_rdata_n, dm_rdata_n;
  logic              wd_done;
  logic              fin;
  logic [DATA_W-1:0] rsp;

  wdog_counter #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
    .clk    (clk),
    .reset  (reset),
    .clr    (state == IDLE),
    .en     (mem_req && !mem_ack),
    .done_c (wd_done)
  );

  // Ack beats the watchdog when both land in the same cycle
  assign fin = mem_ack || wd_done;
  assign rsp = mem_ack ? mem_rdata : ERR_WORD;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cmd      <= '0;
      mem_req  <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      cmd      <= cmd_n;
      mem_req  <= req_n;
      if_rdata <= if_rdata_n;
      dm_rdata <= dm_rdata_n;
      if_valid <= if_valid_n;
      dm_valid <= dm_valid_n;
      err      <= err_n;
    end
  end

  always_comb begin
    state_n    = state;
    cmd_n      = cmd;
    req_n      = mem_req;
    if_rdata_n = if_rdata;
    dm_rdata_n = dm_rdata;
    if_valid_n = 1'b0;
    dm_valid_n = 1'b0;
    err_n      = err;
    case (state)
      // A port whose valid is pulsing still holds req for the same instruction
      IDLE: begin
        if (dm_req && !dm_valid) begin
          state_n     = DACC;
          req_n       = 1'b1;
          cmd_n.we    = dm_we;
          cmd_n.addr  = dm_addr;
          cmd_n.wdata = dm_wdata;
        end else if (if_req && !if_valid) begin
          state_n    = IACC;
          req_n      = 1'b1;
          cmd_n.we   = 1'b0;
          cmd_n.addr = if_addr;
        end
      end
      DACC: begin
        if (fin) begin
          state_n    = IDLE;
          req_n      = 1'b0;
          dm_rdata_n = rsp;
          dm_valid_n = 1'b1;
          err_n      = err || !mem_ack;
        end
      end
      IACC: begin
        if (fin) begin
          state_n    = IDLE;
          req_n      = 1'b0;
          if_rdata_n = rsp;
          if_valid_n = 1'b1;
          err_n      = err || !mem_ack;
        end
      end
      default: begin
        state_n = IDLE;
        req_n   = 1'b0;
      end
    endcase
  end

  assign mem_we    = cmd.we;
  assign mem_addr  = cmd.addr;
  assign mem_wdata = cmd.wdata;
  assign stall_if  = if_req && !if_valid;
  assign stall_mem = dm_req && !dm_valid;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven check of mem_arbiter plus a reset-mid-access sequence.
module tb_mem_arbiter;

  typedef struct packed {
    logic        ifr;
    logic [31:0] ia;
    logic        dr;
    logic        dwe;
    logic [31:0] da;
    logic [31:0] dwd;
    logic        ack;
    logic [31:0] rd;
  } ins_t;

  typedef struct packed {
    logic        mreq;
    logic        mwe;
    logic [31:0] maddr;
    logic [31:0] mwd;
    logic        ifv;
    logic [31:0] ifrd;
    logic        dmv;
    logic [31:0] dmrd;
    logic        sif;
    logic        smem;
    logic        er;
  } outs_t;

  typedef struct packed {
    ins_t  i;
    outs_t o;
  } vec_t;

  localparam logic [31:0] I1 = 32'h2002_0005;
  localparam logic [31:0] D1 = 32'h1111_1111;
  localparam logic [31:0] I2 = 32'h2222_2222;
  localparam logic [31:0] D3 = 32'h3333_3333;
  localparam logic [31:0] D4 = 32'h4444_4444;
  localparam logic [31:0] DB = 32'hDEAD_BEEF;

  logic        clk, reset;
  logic        if_req, if_valid, dm_req, dm_we, dm_valid;
  logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
  logic        mem_req, mem_we, mem_ack, stall_if, stall_mem, err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_vec = 0;
  int n_err = 0;
  vec_t tbl[$];

  mem_arbiter #(.TIMEOUT_CYC(4), .ERR_WORD(32'hDEAD_BEEF)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_valid  (if_valid),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_valid  (dm_valid),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .stall_if  (stall_if),
    .stall_mem (stall_mem),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [31:0] ifr, ia, dr, dwe, da, dwd, ack, rd,
                              input logic [31:0] mreq, mwe, maddr, mwd, ifv, ifrd, dmv, dmrd,
                              input logic [31:0] sif, smem, er);
    vec_t v;
    v.i = '{ifr[0], ia, dr[0], dwe[0], da, dwd, ack[0], rd};
    v.o = '{mreq[0], mwe[0], maddr, mwd, ifv[0], ifrd, dmv[0], dmrd, sif[0], smem[0], er[0]};
    return v;
  endfunction

  task automatic apply(input ins_t i);
    if_req    = i.ifr;
    if_addr   = i.ia;
    dm_req    = i.dr;
    dm_we     = i.dwe;
    dm_addr   = i.da;
    dm_wdata  = i.dwd;
    mem_ack   = i.ack;
    mem_rdata = i.rd;
  endtask

  task automatic chk(input string name, input outs_t exp);
    outs_t got;
    got = '{mem_req, mem_we, mem_addr, mem_wdata, if_valid, if_rdata,
            dm_valid, dm_rdata, stall_if, stall_mem, err};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  initial begin
    // fetch only, ack in first mem_req cycle
    tbl.push_back(mk(1,'h40,0,0,0,0,0,0,           0,0,0,0,     0,0,  0,0,  1,0,0));
    tbl.push_back(mk(1,'h40,0,0,0,0,1,I1,          1,0,'h40,0,  0,0,  0,0,  1,0,0));
    tbl.push_back(mk(1,'h40,0,0,0,0,0,0,           0,0,'h40,0,  1,I1, 0,0,  0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,              0,0,'h40,0,  0,I1, 0,0,  0,0,0));
    // contention, ack latency 3: data first, fetch granted in dm_valid cycle
    tbl.push_back(mk(1,'h44,1,0,'h50,0,0,0,        0,0,'h40,0,  0,I1, 0,0,  1,1,0));
    tbl.push_back(mk(1,'h44,1,0,'h50,0,0,0,        1,0,'h50,0,  0,I1, 0,0,  1,1,0));
    tbl.push_back(mk(1,'h44,1,0,'h50,0,0,0,        1,0,'h50,0,  0,I1, 0,0,  1,1,0));
    tbl.push_back(mk(1,'h44,1,0,'h50,0,1,D1,       1,0,'h50,0,  0,I1, 0,0,  1,1,0));
    tbl.push_back(mk(1,'h44,1,0,'h50,0,0,0,        0,0,'h50,0,  0,I1, 1,D1, 1,0,0));
    tbl.push_back(mk(1,'h44,0,0,0,0,0,0,           1,0,'h44,0,  0,I1, 0,D1, 1,0,0));
    tbl.push_back(mk(1,'h44,0,0,0,0,0,0,           1,0,'h44,0,  0,I1, 0,D1, 1,0,0));
    tbl.push_back(mk(1,'h44,0,0,0,0,1,I2,          1,0,'h44,0,  0,I1, 0,D1, 1,0,0));
    tbl.push_back(mk(1,'h44,0,0,0,0,0,0,           0,0,'h44,0,  1,I2, 0,D1, 0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,              0,0,'h44,0,  0,I2, 0,D1, 0,0,0));
    // store; req held through the dm_valid cycle must not re-issue
    tbl.push_back(mk(0,0,1,1,'h54,7,0,0,           0,0,'h44,0,  0,I2, 0,D1, 0,1,0));
    tbl.push_back(mk(0,0,1,1,'h54,7,0,0,           1,1,'h54,7,  0,I2, 0,D1, 0,1,0));
    tbl.push_back(mk(0,0,1,1,'h54,7,1,D3,          1,1,'h54,7,  0,I2, 0,D1, 0,1,0));
    tbl.push_back(mk(0,0,1,1,'h54,7,0,0,           0,1,'h54,7,  0,I2, 1,D3, 0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,              0,1,'h54,7,  0,I2, 0,D3, 0,0,0));
    // ack lands on the terminal watchdog cycle: data wins, no err
    tbl.push_back(mk(0,0,1,0,'h58,0,0,0,           0,1,'h54,7,  0,I2, 0,D3, 0,1,0));
    tbl.push_back(mk(0,0,1,0,'h58,0,0,0,           1,0,'h58,0,  0,I2, 0,D3, 0,1,0));
    tbl.push_back(mk(0,0,1,0,'h58,0,0,0,           1,0,'h58,0,  0,I2, 0,D3, 0,1,0));
    tbl.push_back(mk(0,0,1,0,'h58,0,0,0,           1,0,'h58,0,  0,I2, 0,D3, 0,1,0));
    tbl.push_back(mk(0,0,1,0,'h58,0,1,D4,          1,0,'h58,0,  0,I2, 0,D3, 0,1,0));
    tbl.push_back(mk(0,0,1,0,'h58,0,0,0,           0,0,'h58,0,  0,I2, 1,D4, 0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,              0,0,'h58,0,  0,I2, 0,D4, 0,0,0));
    // timeout after 4 unacked cycles, then ack in IDLE ignored
    tbl.push_back(mk(0,0,1,0,'h5c,0,0,0,           0,0,'h58,0,  0,I2, 0,D4, 0,1,0));
    tbl.push_back(mk(0,0,1,0,'h5c,0,0,0,           1,0,'h5c,0,  0,I2, 0,D4, 0,1,0));
    tbl.push_back(mk(0,0,1,0,'h5c,0,0,0,           1,0,'h5c,0,  0,I2, 0,D4, 0,1,0));
    tbl.push_back(mk(0,0,1,0,'h5c,0,0,0,           1,0,'h5c,0,  0,I2, 0,D4, 0,1,0));
    tbl.push_back(mk(0,0,1,0,'h5c,0,0,0,           1,0,'h5c,0,  0,I2, 0,D4, 0,1,0));
    tbl.push_back(mk(0,0,1,0,'h5c,0,0,0,           0,0,'h5c,0,  0,I2, 1,DB, 0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,1,'h5555_5555,    0,0,'h5c,0,  0,I2, 0,DB, 0,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,              0,0,'h5c,0,  0,I2, 0,DB, 0,0,1));

    apply('0);
    reset = 1'b0;
    #1;
    chk("reset_state", '0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < tbl.size(); k++) begin
      apply(tbl[k].i);
      #1;
      chk($sformatf("vec%0d", k), tbl[k].o);
      @(posedge clk); #1;
    end

    // reset during a pending fetch drops mem_req without a clock edge
    apply('{1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0});
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_pending", '{1'b1, 1'b0, 32'h80, 32'h0, 1'b0, I2, 1'b0, DB, 1'b1, 1'b0, 1'b1});
    reset = 1'b0;
    #1;
    chk("rst_async", '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0});
    if_addr = 32'h84;
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_held", '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0});
    end
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    mem_ack   = 1'b1;
    mem_rdata = 32'h6666_6666;
    #1;
    chk("post_rst_req", '{1'b1, 1'b0, 32'h84, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0});
    @(posedge clk); #1;
    mem_ack = 1'b0;
    #1;
    chk("post_rst_fetch", '{1'b0, 1'b0, 32'h84, 32'h0, 1'b1, 32'h6666_6666, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0});
    if_req = 1'b0;
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
